// File: rtl/lock_pkg.sv
// Shared types and helpers for the keypad lock sequencer.
package lock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    CHECK,
    UNLOCKED,
    LOCKOUT
  } state_t;

  localparam logic [15:0] DEFAULT_CODE = 16'h1473;
  localparam int          TIMER_W      = 16;

  // True when all four nibbles are valid decimal digits.
  function automatic logic is_bcd16(input logic [15:0] code);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (code[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module lock_timer
  import lock_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               done
);

  logic [TIMER_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - TIMER_W'(1);
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/lock_sequencer.sv
// Four-digit BCD keypad lock with attempt counting, timed unlock and lockout.
module lock_sequencer #(
  parameter logic [15:0] DEFAULT_CODE   = lock_pkg::DEFAULT_CODE,
  parameter int          MAX_ATTEMPTS   = 3,
  parameter int          LOCKOUT_CYCLES = 100,
  parameter int          UNLOCK_CYCLES  = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  digit,
  input  logic        digit_valid,
  input  logic        clear,
  input  logic        code_wr,
  input  logic [15:0] code_in,
  output logic        status,
  output logic        locked_out,
  output logic [1:0]  fail_cnt,
  output logic        bad_pulse,
  output logic [2:0]  digit_cnt
);

  import lock_pkg::*;

  localparam logic [1:0]         MAX_FAIL     = 2'(MAX_ATTEMPTS);
  localparam logic [TIMER_W-1:0] UNLOCK_LOAD  = TIMER_W'(UNLOCK_CYCLES);
  // Lockout is entered on the same edge that loads the timer, so one cycle is already spent.
  localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);

  state_t      state_reg;
  logic [15:0] code_reg;
  logic [15:0] entry_reg;
  logic [2:0]  digit_cnt_reg;
  logic [1:0]  fail_cnt_reg;
  logic        status_reg;
  logic        locked_out_reg;
  logic        bad_pulse_reg;

  logic        code_match;
  logic        digit_ok;
  logic [1:0]  fail_next;
  logic        timer_load;
  logic [TIMER_W-1:0] timer_load_val;
  logic        timer_done;

  assign code_match     = (entry_reg == code_reg);
  assign digit_ok       = digit_valid && (digit <= 4'd9);
  assign fail_next      = (fail_cnt_reg >= MAX_FAIL) ? MAX_FAIL : fail_cnt_reg + 2'd1;
  assign timer_load     = (state_reg == CHECK);
  assign timer_load_val = code_match ? UNLOCK_LOAD : LOCKOUT_LOAD;

  lock_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_load_val),
    .done     (timer_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      code_reg       <= DEFAULT_CODE;
      entry_reg      <= '0;
      digit_cnt_reg  <= '0;
      fail_cnt_reg   <= '0;
      status_reg     <= 1'b0;
      locked_out_reg <= 1'b0;
      bad_pulse_reg  <= 1'b0;
    end else begin
      bad_pulse_reg <= 1'b0;
      case (state_reg)
        IDLE, ENTRY: begin
          if (clear) begin
            entry_reg     <= '0;
            digit_cnt_reg <= '0;
            state_reg     <= IDLE;
          end else if (digit_ok) begin
            entry_reg     <= {entry_reg[11:0], digit};
            digit_cnt_reg <= digit_cnt_reg + 3'd1;
            state_reg     <= (digit_cnt_reg == 3'd3) ? CHECK : ENTRY;
          end
        end
        CHECK: begin
          digit_cnt_reg <= '0;
          entry_reg     <= '0;
          if (code_match) begin
            fail_cnt_reg <= '0;
            state_reg    <= UNLOCKED;
          end else begin
            fail_cnt_reg  <= fail_next;
            bad_pulse_reg <= 1'b1;
            if (fail_next == MAX_FAIL) begin
              locked_out_reg <= 1'b1;
              state_reg      <= LOCKOUT;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        UNLOCKED: begin
          if (code_wr && is_bcd16(code_in)) code_reg <= code_in;
          if (clear || timer_done) begin
            status_reg <= 1'b0;
            state_reg  <= IDLE;
          end else begin
            status_reg <= 1'b1;
          end
        end
        LOCKOUT: begin
          if (timer_done) begin
            locked_out_reg <= 1'b0;
            fail_cnt_reg   <= '0;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign status     = status_reg;
  assign locked_out = locked_out_reg;
  assign fail_cnt   = fail_cnt_reg;
  assign bad_pulse  = bad_pulse_reg;
  assign digit_cnt  = digit_cnt_reg;

endmodule
